ps2_scan_queue: RTL and testbench

Parametrised PS/2 keyboard receiver: samples the PS/2 clock/data pair, frames and checks 11-bit device-to-host packets, folds `F0`/`E0` prefixes into flagged key events, and queues them in a configurable-depth FIFO for the CPU-side keyboard peripheral. It adds synchroniser and glitch filtering, frame timeout resync, error reporting, and a selectable overflow policy.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_clk_filter.sv | 48 ++++
 rtl/ps2_scan_queue.sv | 164 ++++++++++++++++
 tb/tb_ps2_scan_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] KEYUP     = 8'hF0;
  localparam logic [7:0] KEYEXTEND = 8'hE0;

  typedef struct packed {
    logic       keyup;
    logic       extend;
    logic [7:0] scancode;
  } ps2_event_t;

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 pair, debounces the clock and emits a one-cycle strobe
// on each falling edge of the filtered clock.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_strobe,
  output logic o_data
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_strobe;

  logic w_diff;
  logic w_flip;

  // The filtered level follows the synchronised clock only after FILTER_LEN stable cycles
  assign w_diff = (r_clk_s[1] != r_filt);
  assign w_flip = w_diff && (r_cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_clk_s  <= 2'b00;
      r_dat_s  <= 2'b00;
      r_filt   <= 1'b0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_clk_s  <= {r_clk_s[0], i_ps2_clk};
      r_dat_s  <= {r_dat_s[0], i_ps2_data};
      r_cnt    <= (w_diff && !w_flip) ? r_cnt + CW'(1) : '0;
      r_strobe <= w_flip && !r_clk_s[1];
      if (w_flip) r_filt <= r_clk_s[1];
    end
  end

  assign o_strobe = r_strobe;
  assign o_data   = r_dat_s[1];

endmodule

// File: rtl/ps2_scan_queue.sv
// PS/2 device-to-host receiver: framing, F0/E0 prefix folding, repeat
// suppression and an event FIFO with selectable overflow policy.
module ps2_scan_queue
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 3,
  parameter int unsigned FILTER_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 50000,
  parameter int unsigned SUPPRESS_REPEAT = 1,
  parameter int unsigned OVERWRITE       = 0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  input  logic                pop,
  input  logic                clr_err,
  output logic                valid,
  output logic                keyup,
  output logic                extend,
  output logic [7:0]          scancode,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                frame_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  logic          w_strobe;
  logic          w_data;

  logic [3:0]    r_bitcnt;
  logic [9:0]    r_frame;
  logic [TW-1:0] r_to;
  logic          r_keyup_p;
  logic          r_ext_p;
  ps2_event_t    r_last;
  logic          r_frame_err;
  logic          r_overflow;
  ps2_event_t    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk       (clk),
    .clr       (clr),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_strobe  (w_strobe),
    .o_data    (w_data)
  );

  logic       w_last_bit;
  logic       w_frame_ok;
  logic       w_byte_ok;
  logic       w_bad;
  logic       w_timeout;
  logic [7:0] w_byte;
  logic       w_is_prefix;
  ps2_event_t w_event;
  logic       w_event_rdy;
  logic       w_push;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_wr;
  logic       w_rd;
  logic       w_ovf_set;

  always_comb begin
    w_last_bit  = w_strobe && (r_bitcnt == 4'd10);
    w_frame_ok  = !r_frame[0] && w_data && (^r_frame[9:1]);
    w_byte_ok   = w_last_bit && w_frame_ok;
    w_bad       = w_last_bit && !w_frame_ok;
    w_timeout   = (r_bitcnt != 4'd0) && !w_strobe && (r_to == TW'(TIMEOUT_CYCLES - 1));
    w_byte      = r_frame[8:1];
    w_is_prefix = (w_byte == KEYUP) || (w_byte == KEYEXTEND);
    w_event     = '{keyup: r_keyup_p, extend: r_ext_p, scancode: w_byte};
    w_event_rdy = w_byte_ok && !w_is_prefix;
    w_push      = w_event_rdy && !((SUPPRESS_REPEAT != 0) && (w_event == r_last));
    w_full      = (r_level == LW'(DEPTH));
    w_empty     = (r_level == '0);
    w_pop       = pop && !w_empty;
    // On overwrite the write lands on the oldest slot and the read pointer steps past it
    w_wr        = w_push && (!w_full || w_pop || (OVERWRITE != 0));
    w_rd        = w_pop || (w_push && w_full && (OVERWRITE != 0));
    w_ovf_set   = w_push && w_full && !w_pop;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bitcnt    <= '0;
      r_frame     <= '0;
      r_to        <= '0;
      r_keyup_p   <= 1'b0;
      r_ext_p     <= 1'b0;
      r_last      <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
    end else begin
      if (w_strobe || (r_bitcnt == 4'd0) || w_timeout) r_to <= '0;
      else                                             r_to <= r_to + TW'(1);

      if (w_timeout) begin
        r_bitcnt <= '0;
      end else if (w_strobe) begin
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= '0;
        end else begin
          r_bitcnt          <= r_bitcnt + 4'd1;
          r_frame[r_bitcnt] <= w_data;
        end
      end

      if (w_timeout || w_bad) begin
        r_keyup_p <= 1'b0;
        r_ext_p   <= 1'b0;
      end else if (w_byte_ok) begin
        if (w_byte == KEYUP) begin
          r_keyup_p <= 1'b1;
        end else if (w_byte == KEYEXTEND) begin
          r_ext_p <= 1'b1;
        end else begin
          r_keyup_p <= 1'b0;
          r_ext_p   <= 1'b0;
        end
      end

      if (w_event_rdy) r_last <= w_event;

      if (w_bad || w_timeout) r_frame_err <= 1'b1;
      else if (clr_err)       r_frame_err <= 1'b0;

      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (clr_err) r_overflow <= 1'b0;

      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (w_rd) r_rptr <= r_rptr + PW'(1);
      r_level <= r_level + LW'(w_wr) - LW'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_event;
  end

  ps2_event_t w_head;
  assign w_head    = w_empty ? '0 : r_mem[r_rptr];
  assign valid     = !w_empty;
  assign keyup     = w_head.keyup;
  assign extend    = w_head.extend;
  assign scancode  = w_head.scancode;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_scan_queue.sv
// Scoreboard bench: two receivers on one PS/2 line, one suppressing repeats and
// dropping on full, the other keeping repeats and overwriting the oldest.
module tb_ps2_scan_queue;
  import ps2_pkg::*;

  localparam int unsigned DL = 2;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 400;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic clr, ps2_clk, ps2_data, clr_err, pop_a, pop_b;
  logic va, kua, exa, ova, fea;
  logic vb, kub, exb, ovb, feb;
  logic [7:0] sca, scb;
  logic [DL:0] lva, lvb;

  always #5 clk = ~clk;

  ps2_scan_queue #(.DEPTH_LOG2(DL), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO),
                   .SUPPRESS_REPEAT(1), .OVERWRITE(0)) u_dut_a (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop_a),
    .clr_err(clr_err), .valid(va), .keyup(kua), .extend(exa), .scancode(sca),
    .level(lva), .overflow(ova), .frame_err(fea));

  ps2_scan_queue #(.DEPTH_LOG2(DL), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO),
                   .SUPPRESS_REPEAT(0), .OVERWRITE(1)) u_dut_b (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .pop(pop_b),
    .clr_err(clr_err), .valid(vb), .keyup(kub), .extend(exb), .scancode(scb),
    .level(lvb), .overflow(ovb), .frame_err(feb));

  int checks = 0;
  int errors = 0;

  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [9:0] last_a, last_b;
  bit kp, ep, ovf_a, ovf_b, ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    kp = 0; ep = 0; ovf_a = 0; ovf_b = 0; ferr = 0;
  endtask

  task automatic model_push(input logic [9:0] ev);
    if (ev != last_a) begin
      if (qa.size() < DEPTH) qa.push_back(ev);
      else ovf_a = 1;
    end
    last_a = ev;
    if (qb.size() < DEPTH) begin
      qb.push_back(ev);
    end else begin
      void'(qb.pop_front());
      qb.push_back(ev);
      ovf_b = 1;
    end
    last_b = ev;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok, input bit pp);
    if (pp) begin
      if (qa.size() > 0) void'(qa.pop_front());
      if (qb.size() > 0) void'(qb.pop_front());
    end
    if (!ok) begin
      ferr = 1; kp = 0; ep = 0;
    end else if (b == KEYUP) begin
      kp = 1;
    end else if (b == KEYEXTEND) begin
      ep = 1;
    end else begin
      model_push({kp, ep, b});
      kp = 0; ep = 0;
    end
  endtask

  // Drives nbits of an 11-bit frame; pp pops both queues on the push edge of bit 10
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit pp);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (6) @(negedge clk);
      if (pp && i == 10) begin
        if (qa.size() > 0) check("pp_head_a", 32'({kua, exa, sca}), 32'(qa[0]));
        if (qb.size() > 0) check("pp_head_b", 32'({kub, exb, scb}), 32'(qb[0]));
        ps2_clk = 1'b0;
        repeat (2 + FL) @(posedge clk);
        @(negedge clk); pop_a = 1'b1; pop_b = 1'b1;
        @(negedge clk); pop_a = 1'b0; pop_b = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        ps2_clk = 1'b0;
        repeat (12) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
    model_byte(b, 1'b1, 1'b0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf_a"}, 32'(ova), 32'(ovf_a));
    check({tag, "_ovf_b"}, 32'(ovb), 32'(ovf_b));
    check({tag, "_ferr_a"}, 32'(fea), 32'(ferr));
    check({tag, "_ferr_b"}, 32'(feb), 32'(ferr));
  endtask

  task automatic drain(input string tag);
    check({tag, "_lvl_a"}, 32'(lva), 32'(qa.size()));
    while (qa.size() > 0) begin
      check({tag, "_va"}, 32'(va), 32'd1);
      check({tag, "_head_a"}, 32'({kua, exa, sca}), 32'(qa[0]));
      pop_a = 1'b1;
      @(negedge clk) pop_a = 1'b0;
      void'(qa.pop_front());
    end
    check({tag, "_empty_a"}, 32'(va), 32'd0);
    check({tag, "_lvl_b"}, 32'(lvb), 32'(qb.size()));
    while (qb.size() > 0) begin
      check({tag, "_vb"}, 32'(vb), 32'd1);
      check({tag, "_head_b"}, 32'({kub, exb, scb}), 32'(qb[0]));
      pop_b = 1'b1;
      @(negedge clk) pop_b = 1'b0;
      void'(qb.pop_front());
    end
    check({tag, "_empty_b"}, 32'(vb), 32'd0);
  endtask

  task automatic pulse_clr_err();
    clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    ovf_a = 0; ovf_b = 0; ferr = 0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
  endtask

  initial begin
    clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    clr_err = 1'b0; pop_a = 1'b0; pop_b = 1'b0;
    do_reset();
    check("rst_head_a", 32'({va, kua, exa, sca}), 32'd0);
    check("rst_head_b", 32'({vb, kub, exb, scb}), 32'd0);
    check("rst_lvl_a", 32'(lva), 32'd0);
    check_flags("rst");

    send(8'h1C); send(8'hF0); send(8'h1C);
    check("makebrk_lvl", 32'(lva), 32'd2);
    check_flags("makebrk");
    drain("makebrk");

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext");

    repeat (3) send(8'h1C);
    drain("repeat");

    send_frame(8'h1C, 1'b1, 11, 1'b0);
    model_byte(8'h1C, 1'b0, 1'b0);
    send(8'h2B);
    check_flags("parity");
    drain("parity");
    pulse_clr_err();
    check_flags("parity_clr");

    send_frame(8'h55, 1'b0, 5, 1'b0);
    repeat (TO + 50) @(negedge clk);
    ferr = 1; kp = 0; ep = 0;
    check_flags("timeout");
    pulse_clr_err();
    send(8'h33);
    check_flags("timeout_next");
    drain("timeout");

    for (int i = 1; i <= 5; i++) send(8'(i));
    check_flags("ovf");
    drain("ovf");
    pulse_clr_err();
    check_flags("ovf_clr");

    for (int i = 6; i <= 9; i++) send(8'(i));
    send_frame(8'h0A, 1'b0, 11, 1'b1);
    model_byte(8'h0A, 1'b1, 1'b1);
    check("pp_lvl_a", 32'(lva), 32'd4);
    check("pp_lvl_b", 32'(lvb), 32'd4);
    check_flags("pp");
    drain("pp");

    @(negedge clk) ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h0B);
    check_flags("glitch");
    drain("glitch");

    send_frame(8'h44, 1'b0, 3, 1'b0);
    send(8'hF0);
    do_reset();
    check_flags("midrst");
    send(8'h0C);
    drain("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
